// File: rtl/game_timer_display.sv
// Puzzle elapsed-time counter (MM:SS, BCD) with a multiplexed 4-digit
// active-low seven-segment driver and a post-solve blink.
module game_timer_display #(
  parameter int MAX_MIN     = 99,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       segclk,
  input  logic       clk1hz,
  input  logic       start,
  input  logic       pause,
  input  logic       solved,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       saturated,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] seg_sync_q, hz_sync_q;
  logic                   seg_hist_q, hz_hist_q;
  logic                   seg_tick, hz_tick, hz_level;

  logic [3:0] sec_o_q, sec_t_q, min_o_q, min_t_q;
  logic [3:0] sec_o_d, sec_t_d, min_o_d, min_t_d;
  logic       sat_q, sat_d;
  logic       clear, count_en, at_max;

  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] digit;

  // Divided clocks are plain data here: synchronize, then edge-detect.
  always_ff @(posedge clk) begin
    if (clr) begin
      seg_sync_q <= '0;
      hz_sync_q  <= '0;
      seg_hist_q <= 1'b0;
      hz_hist_q  <= 1'b0;
    end else begin
      seg_sync_q[0] <= segclk;
      hz_sync_q[0]  <= clk1hz;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        seg_sync_q[i] <= seg_sync_q[i-1];
        hz_sync_q[i]  <= hz_sync_q[i-1];
      end
      seg_hist_q <= seg_sync_q[SYNC_STAGES-1];
      hz_hist_q  <= hz_sync_q[SYNC_STAGES-1];
    end
  end

  assign seg_tick = seg_sync_q[SYNC_STAGES-1] & ~seg_hist_q;
  assign hz_tick  = hz_sync_q[SYNC_STAGES-1] & ~hz_hist_q;
  assign hz_level = hz_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (solved) begin
          state_d = DONE;
        end else if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end else if (pause) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (solved) begin
          state_d = DONE;
        end else if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end else if (pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A 1 Hz tick only counts when nothing else changes the state this cycle.
  assign count_en = hz_tick && (state_q == RUN) && (state_d == RUN) && !clear;
  assign at_max   = (min_t_q == MAX_T) && (min_o_q == MAX_O) &&
                    (sec_t_q == 4'd5) && (sec_o_q == 4'd9);

  always_comb begin
    sec_o_d = sec_o_q;
    sec_t_d = sec_t_q;
    min_o_d = min_o_q;
    min_t_d = min_t_q;
    if (clear) begin
      sec_o_d = 4'd0;
      sec_t_d = 4'd0;
      min_o_d = 4'd0;
      min_t_d = 4'd0;
    end else if (count_en && !at_max) begin
      if (sec_o_q == 4'd9) begin
        sec_o_d = 4'd0;
        if (sec_t_q == 4'd5) begin
          sec_t_d = 4'd0;
          if (min_o_q == 4'd9) begin
            min_o_d = 4'd0;
            min_t_d = min_t_q + 4'd1;
          end else begin
            min_o_d = min_o_q + 4'd1;
          end
        end else begin
          sec_t_d = sec_t_q + 4'd1;
        end
      end else begin
        sec_o_d = sec_o_q + 4'd1;
      end
    end
    sat_d = (min_t_d == MAX_T) && (min_o_d == MAX_O) &&
            (sec_t_d == 4'd5) && (sec_o_d == 4'd9);
  end

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    idx_d = idx_q;
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    digit = sec_o_q;
    if (seg_tick) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_d)
        2'd0: digit = sec_o_q;
        2'd1: digit = sec_t_q;
        2'd2: digit = min_o_q;
        2'd3: digit = min_t_q;
        default: digit = sec_o_q;
      endcase
      an_d = ~(4'b0001 << idx_d);
      dp_d = !((idx_d == 2'd2) && (state_q != IDLE));
      if (state_q == IDLE) begin
        seg_d = seg_enc(4'd0);
      end else if ((state_q == DONE) && hz_level) begin
        seg_d = 7'h7F;
      end else begin
        seg_d = seg_enc(digit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sec_o_q <= 4'd0;
      sec_t_q <= 4'd0;
      min_o_q <= 4'd0;
      min_t_q <= 4'd0;
      sat_q   <= 1'b0;
      idx_q   <= 2'd3;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      sec_o_q <= sec_o_d;
      sec_t_q <= sec_t_d;
      min_o_q <= min_o_d;
      min_t_q <= min_t_d;
      sat_q   <= sat_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign dp        = dp_q;
  assign min_bcd   = {min_t_q, min_o_q};
  assign sec_bcd   = {sec_t_q, sec_o_q};
  assign saturated = sat_q;
  assign state_o   = state_q;

endmodule
